// File: rtl/pll_lock_reset_gen.sv
// Qualifies the synchronised PLL lock flag, stretches the core reset and generates
// phase-aligned clock enables for the core; also counts lock losses seen while running.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | core held in reset, waiting for synchronised lock
// STABILIZE | counting consecutive locked cycles up to LOCK_CYCLES
// STRETCH   | lock qualified, holding reset for STRETCH_CYCLES
// RUN       | core released, clock enables active

module pll_lock_reset_gen #(
    parameter int LOCK_CYCLES    = 1024,
    parameter int STRETCH_CYCLES = 16,
    parameter int CE_DIV         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_reset,
    output logic       core_reset_n,
    output logic       ce_main,
    output logic       ce_half,
    output logic       running,
    output logic [7:0] lock_loss_cnt
);
    localparam int LCW = $clog2(LOCK_CYCLES) + 1;
    localparam int SCW = $clog2(STRETCH_CYCLES) + 1;
    localparam int PHW = $clog2(CE_DIV) + 1;
    localparam logic [LCW-1:0] LOCK_TC = LCW'(LOCK_CYCLES);
    localparam logic [SCW-1:0] STR_LD  = SCW'(STRETCH_CYCLES);
    localparam logic [PHW-1:0] PH_MAIN = PHW'(CE_DIV - 1);
    localparam logic [PHW-1:0] PH_HALF = PHW'(CE_DIV / 2 - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        STRETCH   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             lk_meta_q, lk_meta_d;
    logic             lk_s_q, lk_s_d;
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [SCW-1:0]   str_cnt_q, str_cnt_d;
    logic [PHW-1:0]   phase_q, phase_d;
    logic             core_reset_n_q, core_reset_n_d;
    logic             running_q, running_d;
    logic             ce_main_q, ce_main_d;
    logic             ce_half_q, ce_half_d;
    logic [7:0]       loss_q, loss_d;

    always_comb begin
        state_d    = state_q;
        lk_meta_d  = pll_locked;
        lk_s_d     = lk_meta_q;
        lock_cnt_d = lock_cnt_q;
        str_cnt_d  = str_cnt_q;
        loss_d     = loss_q;

        case (state_q)
            WAIT_LOCK: begin
                if (lk_s_q) begin
                    state_d    = STABILIZE;
                    lock_cnt_d = LCW'(1);
                end else begin
                    lock_cnt_d = '0;
                end
            end
            STABILIZE: begin
                if (!lk_s_q) begin
                    state_d    = WAIT_LOCK;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LCW'(1);
                    if (lock_cnt_d == LOCK_TC) begin
                        state_d   = STRETCH;
                        str_cnt_d = STR_LD;
                    end
                end
            end
            STRETCH: begin
                if (!lk_s_q) begin
                    state_d    = WAIT_LOCK;
                    lock_cnt_d = '0;
                end else if (soft_reset) begin
                    str_cnt_d = STR_LD;
                end else if (str_cnt_q == SCW'(1)) begin
                    state_d = RUN;
                end else begin
                    str_cnt_d = str_cnt_q - SCW'(1);
                end
            end
            RUN: begin
                // Lock loss takes priority over a simultaneous soft reset request.
                if (!lk_s_q) begin
                    state_d    = WAIT_LOCK;
                    lock_cnt_d = '0;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end else if (soft_reset) begin
                    state_d   = STRETCH;
                    str_cnt_d = STR_LD;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase

        core_reset_n_d = (state_q == RUN);
        running_d      = (state_q == RUN);

        // Phase only advances once the released reset is visible, so the first
        // ce_main lands CE_DIV cycles after core_reset_n rises.
        if (core_reset_n_q && core_reset_n_d) begin
            phase_d = (phase_q == PH_MAIN) ? '0 : phase_q + PHW'(1);
        end else begin
            phase_d = '0;
        end
        ce_main_d = core_reset_n_q && core_reset_n_d && (phase_q == PH_MAIN);
        ce_half_d = core_reset_n_q && core_reset_n_d && (phase_q == PH_HALF);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= WAIT_LOCK;
            lk_meta_q      <= 1'b0;
            lk_s_q         <= 1'b0;
            lock_cnt_q     <= '0;
            str_cnt_q      <= '0;
            phase_q        <= '0;
            core_reset_n_q <= 1'b0;
            running_q      <= 1'b0;
            ce_main_q      <= 1'b0;
            ce_half_q      <= 1'b0;
            loss_q         <= 8'd0;
        end else begin
            state_q        <= state_d;
            lk_meta_q      <= lk_meta_d;
            lk_s_q         <= lk_s_d;
            lock_cnt_q     <= lock_cnt_d;
            str_cnt_q      <= str_cnt_d;
            phase_q        <= phase_d;
            core_reset_n_q <= core_reset_n_d;
            running_q      <= running_d;
            ce_main_q      <= ce_main_d;
            ce_half_q      <= ce_half_d;
            loss_q         <= loss_d;
        end
    end

    assign core_reset_n  = core_reset_n_q;
    assign running       = running_q;
    assign ce_main       = ce_main_q;
    assign ce_half       = ce_half_q;
    assign lock_loss_cnt = loss_q;

endmodule
